// File: rtl/frame_sequencer.sv
// Frame sequencer: queues {polarity,state} requests in a 4-deep FIFO and drives
// start/polarity/state to a serial transmitter, with timeout, release and gap phases.
module frame_sequencer #(
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_pol,
    input  logic        req_state,
    output logic        req_ready,
    input  logic        flush,
    input  logic        eoc,
    output logic        start,
    output logic        polarity,
    output logic        state,
    output logic        busy,
    output logic [2:0]  fifo_level,
    output logic        frame_done,
    output logic        timeout_err,
    output logic [15:0] frame_count
);

    typedef enum logic [1:0] {IDLE, SEND, RELEASE, GAP} fsm_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD     = 8'(GAP_CYCLES - 1);

    fsm_t       fsm;
    logic [1:0] mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] level;
    logic [7:0] tcnt;
    logic [7:0] gcnt;
    logic       push;
    logic       pop;

    assign req_ready  = (level != 3'd4) && !flush;
    assign push       = req_valid && req_ready;
    // Only IDLE pops, and flush cancels it, so a pop never sees the entry pushed on the same edge.
    assign pop        = (fsm == IDLE) && (level != 3'd0) && !flush;
    assign fifo_level = level;
    assign busy       = (fsm != IDLE);

    // NOTE: storage has no reset; validity is tracked by the pointers and level alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_pol, req_state};
        end
    end

    // NOTE: all clocked state uses non-blocking assignments so every block sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            level <= level + 3'(push) - 3'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm         <= IDLE;
            start       <= 1'b0;
            polarity    <= 1'b0;
            state       <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            frame_count <= '0;
            tcnt        <= '0;
            gcnt        <= '0;
        end else begin
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (pop) begin
                        {polarity, state} <= mem[rd_ptr];
                        start <= 1'b1;
                        tcnt  <= '0;
                        fsm   <= SEND;
                    end
                end
                SEND: begin
                    tcnt <= tcnt + 8'd1;
                    // Priority: flush aborts silently, then eoc beats a coincident timeout.
                    if (flush) begin
                        start <= 1'b0;
                        fsm   <= RELEASE;
                    end else if (eoc) begin
                        start       <= 1'b0;
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        fsm         <= RELEASE;
                    end else if (tcnt == TIMEOUT_LAST) begin
                        start       <= 1'b0;
                        timeout_err <= 1'b1;
                        fsm         <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!eoc) begin
                        gcnt <= GAP_LOAD;
                        fsm  <= GAP;
                    end
                end
                GAP: begin
                    if (gcnt == 8'd0) fsm <= IDLE;
                    else              gcnt <= gcnt - 8'd1;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: a table of push vectors plus hand-written
// multi-cycle sequences, with a small transmitter model answering start with eoc.
module tb_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_pol = 1'b0;
    logic        req_state = 1'b0;
    logic        req_ready;
    logic        flush = 1'b0;
    logic        eoc = 1'b0;
    logic        start;
    logic        polarity;
    logic        state;
    logic        busy;
    logic [2:0]  fifo_level;
    logic        frame_done;
    logic        timeout_err;
    logic [15:0] frame_count;

    int total = 0;
    int bad   = 0;

    // Transmitter model: mode 0 holds eoc low, mode 1 raises eoc eoc_delay clocks after start rises.
    int xmit_mode  = 1;
    int eoc_delay  = 20;
    int hi_cnt     = 0;

    frame_sequencer #(.GAP_CYCLES(8), .TIMEOUT_CYCLES(200)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_pol(req_pol),
        .req_state(req_state), .req_ready(req_ready), .flush(flush), .eoc(eoc),
        .start(start), .polarity(polarity), .state(state), .busy(busy),
        .fifo_level(fifo_level), .frame_done(frame_done), .timeout_err(timeout_err),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (xmit_mode == 1 && start) begin
            if (hi_cnt == eoc_delay) eoc = 1'b1;
            hi_cnt = hi_cnt + 1;
        end else begin
            hi_cnt = 0;
            eoc    = 1'b0;
        end
    end

    typedef struct {
        logic       v;
        logic       p;
        logic       s;
        logic [2:0] lvl;
        logic       rdy;
        logic       st;
        logic       pol;
        logic       sta;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic p, input logic s);
        req_valid = 1'b1;
        req_pol   = p;
        req_state = s;
        step();
        req_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    // Waits for start, then counts high samples and pulses up to and including the fall sample.
    task automatic measure_frame(output int hi, output int dn, output int to);
        int n;
        hi = 0; dn = 0; to = 0; n = 0;
        while (!start && n < 100) begin step(); n++; end
        check("start_rise_wait", 32'(start), 32'd1);
        if (!start) return;
        while (start && hi < 1000) begin
            hi++;
            step();
            dn += int'(frame_done);
            to += int'(timeout_err);
        end
    endtask

    // Counts samples after the start-fall sample until busy drops.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 1000) begin step(); n++; end
        check("idle_wait", 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t vecs [7];
        logic [1:0] exp_q [$];
        int hi, dn, to, n, low_run, seen, starts, pulses;
        logic prev_start;

        // Reset state
        do_reset();
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_start", 32'(start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(frame_count), 32'd0);
        check("rst_pulses", {30'd0, frame_done, timeout_err}, 32'd0);

        // Table: back-to-back pushes; first frame starts on the second edge after its push
        vecs[0] = '{1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1};
        xmit_mode = 1;
        eoc_delay = 20;
        for (int i = 0; i < 7; i++) begin
            req_valid = vecs[i].v;
            req_pol   = vecs[i].p;
            req_state = vecs[i].s;
            step();
            check($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vecs[i].lvl));
            check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].rdy));
            check($sformatf("vec%0d_start", i), 32'(start), 32'(vecs[i].st));
            check($sformatf("vec%0d_pol", i), 32'(polarity), 32'(vecs[i].pol));
            check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].sta));
        end
        req_valid = 1'b0;

        // Remaining frames issue in order; start is low for 10 samples between frames
        // (fall edge, RELEASE edge, 8 GAP edges) before the next pop.
        exp_q = '{2'b10, 2'b01, 2'b00, 2'b11};
        seen = 0; low_run = 0; pulses = 0; n = 0;
        prev_start = start;
        while ((seen < 4 || busy) && n < 2000) begin
            step();
            n++;
            pulses += int'(timeout_err);
            if (start && !prev_start) begin
                check($sformatf("b2b_gap%0d", seen), 32'(low_run), 32'd10);
                check($sformatf("b2b_order%0d", seen), 32'({polarity, state}), 32'(exp_q[seen]));
                seen++;
                low_run = 0;
            end else if (!start) begin
                low_run++;
            end
            prev_start = start;
        end
        check("b2b_frames_seen", 32'(seen), 32'd4);
        check("b2b_count", 32'(frame_count), 32'd5);
        check("b2b_timeouts", 32'(pulses), 32'd0);
        check("b2b_level", 32'(fifo_level), 32'd0);

        // Single frame: eoc 101 clocks after start rises
        do_reset();
        xmit_mode = 1;
        eoc_delay = 101;
        push(1'b1, 1'b0);
        measure_frame(hi, dn, to);
        check("single_high", 32'(hi), 32'd102);
        check("single_done", 32'(dn), 32'd1);
        check("single_to", 32'(to), 32'd0);
        check("single_pol", 32'(polarity), 32'd1);
        check("single_state", 32'(state), 32'd0);
        check("single_count", 32'(frame_count), 32'd1);
        wait_idle(n);
        check("single_idle_delay", 32'(n), 32'd9);

        // Reset 50 clocks into a frame with requests queued
        xmit_mode = 0;
        push(1'b1, 1'b1);
        push(1'b0, 1'b1);
        push(1'b1, 1'b0);
        n = 0;
        while (n < 48 && start) begin step(); n++; end
        check("rstmid_start_before", 32'(start), 32'd1);
        check("rstmid_level_before", 32'(fifo_level), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check("rstmid_start", 32'(start), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_count", 32'(frame_count), 32'd0);
        check("rstmid_level", 32'(fifo_level), 32'd0);
        check("rstmid_pol", 32'({polarity, state}), 32'd0);
        step();
        rst = 1'b1;
        #1;
        check("rstmid_ready", 32'(req_ready), 32'd1);
        starts = 0;
        for (int i = 0; i < 20; i++) begin step(); starts += int'(start); end
        check("rstmid_no_frames", 32'(starts), 32'd0);

        // Timeout: eoc held low
        do_reset();
        xmit_mode = 0;
        push(1'b0, 1'b1);
        measure_frame(hi, dn, to);
        check("to_high", 32'(hi), 32'd200);
        check("to_pulse", 32'(to), 32'd1);
        check("to_done", 32'(dn), 32'd0);
        check("to_count", 32'(frame_count), 32'd0);
        wait_idle(n);
        check("to_idle_delay", 32'(n), 32'd9);

        // eoc sampled on the very edge the timeout is reached
        do_reset();
        xmit_mode = 1;
        eoc_delay = 199;
        push(1'b1, 1'b1);
        measure_frame(hi, dn, to);
        check("sim_high", 32'(hi), 32'd200);
        check("sim_done", 32'(dn), 32'd1);
        check("sim_to", 32'(to), 32'd0);
        check("sim_count", 32'(frame_count), 32'd1);
        // Queue two during RELEASE/GAP, then push on the IDLE pop edge
        push(1'b0, 1'b0);
        push(1'b0, 1'b1);
        wait_idle(n);
        check("sim_level_idle", 32'(fifo_level), 32'd2);
        push(1'b1, 1'b0);
        check("pushpop_level", 32'(fifo_level), 32'd2);
        check("pushpop_start", 32'(start), 32'd1);
        check("pushpop_first", 32'({polarity, state}), 32'd0);

        // Flush mid-SEND with three entries queued
        do_reset();
        xmit_mode = 0;
        push(1'b1, 1'b1);
        push(1'b0, 1'b1);
        push(1'b1, 1'b0);
        push(1'b0, 1'b0);
        step();
        step();
        check("fl_level_before", 32'(fifo_level), 32'd3);
        check("fl_start_before", 32'(start), 32'd1);
        flush = 1'b1;
        #1;
        check("fl_ready_low", 32'(req_ready), 32'd0);
        step();
        flush = 1'b0;
        check("fl_start", 32'(start), 32'd0);
        check("fl_level", 32'(fifo_level), 32'd0);
        check("fl_pulses", {30'd0, frame_done, timeout_err}, 32'd0);
        starts = 0; pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            starts += int'(start);
            pulses += int'(frame_done) + int'(timeout_err);
        end
        check("fl_no_frames", 32'(starts), 32'd0);
        check("fl_no_pulses", 32'(pulses), 32'd0);
        check("fl_busy", 32'(busy), 32'd0);
        check("fl_count", 32'(frame_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
